// File: rtl/axi_rd_arb.sv
// Two-requester AXI read arbiter: round-robin AR grant with per-requester
// outstanding-burst limits, and zero-latency R routing on the ID tag bit.
module axi_rd_arb #(
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned ID_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        s_arvalid,
  output logic [1:0]        s_arready,
  input  logic [2*ID_W-1:0] s_arid,
  input  logic [127:0]      s_araddr,
  input  logic [15:0]       s_arlen,
  input  logic [5:0]        s_arsize,
  output logic [1:0]        s_rvalid,
  input  logic [1:0]        s_rready,
  output logic [ID_W-1:0]   s_rid,
  output logic [511:0]      s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rlast,
  output logic              s_ruser,
  output logic              m_arvalid,
  input  logic              m_arready,
  output logic [ID_W-1:0]   m_arid,
  output logic [63:0]       m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  input  logic              m_rvalid,
  output logic              m_rready,
  input  logic [ID_W-1:0]   m_rid,
  input  logic [511:0]      m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic              m_ruser
);

  localparam int unsigned    CW      = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  state_e                 state_q, state_d;
  logic                   g_q, g_d;
  logic                   last_q, last_d;
  logic [1:0][CW-1:0]     cnt_q, cnt_d;
  logic [1:0]             elig_s;
  logic [1:0]             inc_s;
  logic [1:0]             dec_s;
  logic                   ar_hs_s;
  logic                   r_tag_s;
  logic                   unused_tag_s;

  // Requester-supplied tag bits are overwritten by the grant index.
  assign unused_tag_s = &{1'b0, s_arid[ID_W-1], s_arid[2*ID_W-1]};

  // State, grant and outstanding counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      g_q     <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Eligibility, handshake and counter update terms.
  always_comb begin
    r_tag_s  = m_rid[ID_W-1];
    elig_s   = 2'b00;
    elig_s[0] = s_arvalid[0] && (cnt_q[0] < CNT_MAX);
    elig_s[1] = s_arvalid[1] && (cnt_q[1] < CNT_MAX);
    ar_hs_s  = (state_q == ST_BUSY) && m_arready;
    inc_s    = {ar_hs_s && g_q, ar_hs_s && !g_q};
    dec_s    = 2'b00;
    if (m_rvalid && m_rready && m_rlast) begin
      dec_s = r_tag_s ? 2'b10 : 2'b01;
    end else begin
      dec_s = 2'b00;
    end
  end

  // Next-state: grant latch in IDLE, hold until downstream accepts in BUSY.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (elig_s != 2'b00) begin
          state_d = ST_BUSY;
          g_d     = (&elig_s) ? ~last_q : elig_s[1];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (m_arready) begin
          state_d = ST_IDLE;
          last_d  = g_q;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counters: simultaneous inc/dec cancel, saturate at 0 and MAX_OUT.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      case ({inc_s[i], dec_s[i]})
        2'b10:   cnt_d[i] = (cnt_q[i] < CNT_MAX) ? cnt_q[i] + CNT_ONE : cnt_q[i];
        2'b01:   cnt_d[i] = (cnt_q[i] != CNT_ZERO) ? cnt_q[i] - CNT_ONE : cnt_q[i];
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // AR outputs decoded from the registered state and grant.
  always_comb begin
    m_arvalid = (state_q == ST_BUSY);
    if (ar_hs_s) begin
      s_arready = g_q ? 2'b10 : 2'b01;
    end else begin
      s_arready = 2'b00;
    end
    if (g_q) begin
      m_arid   = {1'b1, s_arid[2*ID_W-2:ID_W]};
      m_araddr = s_araddr[127:64];
      m_arlen  = s_arlen[15:8];
      m_arsize = s_arsize[5:3];
    end else begin
      m_arid   = {1'b0, s_arid[ID_W-2:0]};
      m_araddr = s_araddr[63:0];
      m_arlen  = s_arlen[7:0];
      m_arsize = s_arsize[2:0];
    end
  end

  // R path: pure steering on the tag bit, no buffering.
  always_comb begin
    if (m_rvalid) begin
      s_rvalid = r_tag_s ? 2'b10 : 2'b01;
    end else begin
      s_rvalid = 2'b00;
    end
    m_rready = s_rready[r_tag_s];
    s_rid    = {1'b0, m_rid[ID_W-2:0]};
    s_rdata  = m_rdata;
    s_rresp  = m_rresp;
    s_rlast  = m_rlast;
    s_ruser  = m_ruser;
  end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Self-checking bench for axi_rd_arb (MAX_OUT=2): R routing table, directed
// AR corner sequences, and randomized traffic against a transaction model.
module tb_axi_rd_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   s_arvalid, s_arready, s_rvalid, s_rready;
  logic [31:0]  s_arid;
  logic [127:0] s_araddr;
  logic [15:0]  s_arlen;
  logic [5:0]   s_arsize;
  logic [15:0]  s_rid, m_arid, m_rid;
  logic [511:0] s_rdata, m_rdata;
  logic [1:0]   s_rresp, m_rresp;
  logic         s_rlast, s_ruser, m_arvalid, m_arready, m_rvalid, m_rready;
  logic         m_rlast, m_ruser;
  logic [63:0]  m_araddr;
  logic [7:0]   m_arlen;
  logic [2:0]   m_arsize;

  int checks = 0;
  int failures = 0;

  axi_rd_arb #(.MAX_OUT(2), .ID_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_ruser(s_ruser),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_ruser(m_ruser)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s_arvalid = 2'b00; s_arid = 32'h0; s_araddr = 128'h0; s_arlen = 16'h0;
    s_arsize = 6'h0; s_rready = 2'b00; m_arready = 1'b0; m_rvalid = 1'b0;
    m_rid = 16'h0; m_rdata = 512'h0; m_rresp = 2'b00; m_rlast = 1'b0; m_ruser = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk); #1;
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_arready", s_arready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Advance to the next falling edge and let combinational outputs settle.
  task automatic cyc();
    @(negedge clk); #1;
  endtask

  typedef struct {
    logic        mrv;
    logic [15:0] mrid;
    logic [1:0]  srr;
    logic [1:0]  exp_srv;
    logic        exp_mrr;
    logic [15:0] exp_srid;
  } rvec_t;

  rvec_t tbl[6];

  // Transaction-level reference state for the random phase.
  int cnt[2];
  int pend;
  int last;

  initial begin
    logic [511:0] rd;
    logic [15:0]  exp_id;
    int           tag, e0, e1, delta;

    tbl[0] = '{1'b1, 16'h8003, 2'b01, 2'b10, 1'b0, 16'h0003};
    tbl[1] = '{1'b1, 16'h8003, 2'b11, 2'b10, 1'b1, 16'h0003};
    tbl[2] = '{1'b1, 16'h0003, 2'b01, 2'b01, 1'b1, 16'h0003};
    tbl[3] = '{1'b0, 16'h8007, 2'b10, 2'b00, 1'b1, 16'h0007};
    tbl[4] = '{1'b1, 16'h7fff, 2'b10, 2'b01, 1'b0, 16'h7fff};
    tbl[5] = '{1'b1, 16'hffff, 2'b10, 2'b10, 1'b1, 16'h7fff};

    do_reset();
    foreach (tbl[k]) begin
      m_rvalid = tbl[k].mrv; m_rid = tbl[k].mrid; s_rready = tbl[k].srr;
      #1;
      chk($sformatf("rt%0d_srvalid", k), s_rvalid, tbl[k].exp_srv);
      chk($sformatf("rt%0d_mrready", k), m_rready, tbl[k].exp_mrr);
      chk($sformatf("rt%0d_srid", k), s_rid, tbl[k].exp_srid);
    end

    // Alternating grants, one AR every two cycles, until both hit MAX_OUT.
    do_reset();
    s_arvalid = 2'b11; m_arready = 1'b1; s_arid = 32'h1234_5678;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      chk($sformatf("rr%0d_valid", i), m_arvalid, (i <= 8) && (i % 2 == 1));
      if ((i <= 8) && (i % 2 == 1))
        chk($sformatf("rr%0d_tag", i), m_arid[15], ((i - 1) / 2) % 2);
    end

    // Stalled downstream: payload held, single s_arready pulse.
    do_reset();
    s_arvalid = 2'b01; s_arid = 32'h0000_8005; m_arready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("stall_valid", m_arvalid, 1'b1);
      chk("stall_id", m_arid, 16'h0005);
      chk("stall_ready", s_arready, 2'b00);
    end
    m_arready = 1'b1; #1;
    chk("stall_pulse", s_arready, 2'b01);
    cyc();
    s_arvalid = 2'b00;
    chk("stall_after", s_arready, 2'b00);

    // Outstanding limit for requester 1; requester 0 still served.
    do_reset();
    s_arvalid = 2'b10; m_arready = 1'b1;
    repeat (6) cyc();
    chk("lim_block", m_arvalid, 1'b0);
    s_arvalid = 2'b11;
    cyc();
    chk("lim_r0_valid", m_arvalid, 1'b1);
    chk("lim_r0_tag", m_arid[15], 1'b0);
    cyc();
    s_arvalid = 2'b10; m_rvalid = 1'b1; m_rid = 16'h8000; m_rlast = 1'b1; s_rready = 2'b10;
    #1 chk("lim_rready", m_rready, 1'b1);
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    chk("lim_idle", m_arvalid, 1'b0);
    cyc();
    chk("lim_r1_valid", m_arvalid, 1'b1);
    chk("lim_r1_tag", m_arid[15], 1'b1);

    // Simultaneous AR handshake and rlast on requester 0 leaves count at 1.
    do_reset();
    s_arvalid = 2'b01; m_arready = 1'b1;
    cyc();
    s_arvalid = 2'b00;
    cyc();
    s_arvalid = 2'b01;
    cyc();
    chk("same_busy", m_arvalid, 1'b1);
    m_rvalid = 1'b1; m_rid = 16'h0000; m_rlast = 1'b1; s_rready = 2'b01;
    cyc();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    cyc();
    chk("same_second", m_arvalid, 1'b1);
    cyc();
    cyc();
    chk("same_blocked", m_arvalid, 1'b0);

    // Asynchronous reset while BUSY on requester 1.
    do_reset();
    s_arvalid = 2'b10; m_arready = 1'b0;
    cyc();
    chk("arst_busy", m_arvalid, 1'b1);
    m_arready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", m_arvalid, 1'b0);
    chk("arst_ready", s_arready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1; s_arvalid = 2'b11;
    cyc();
    chk("arst_first", m_arvalid, 1'b1);
    chk("arst_first_tag", m_arid[15], 1'b0);

    // Randomized traffic against the transaction model.
    do_reset();
    cnt[0] = 0; cnt[1] = 0; pend = -1; last = 1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      s_arvalid = 2'($urandom);
      m_arready = 1'($urandom);
      s_arid    = $urandom;
      s_araddr  = {$urandom, $urandom, $urandom, $urandom};
      s_arlen   = 16'($urandom);
      s_arsize  = 6'($urandom);
      m_rvalid  = 1'($urandom);
      m_rid     = 16'($urandom);
      m_rlast   = 1'($urandom);
      m_rresp   = 2'($urandom);
      m_ruser   = 1'($urandom);
      s_rready  = 2'($urandom);
      for (int k = 0; k < 16; k++) rd[k*32 +: 32] = $urandom;
      m_rdata = rd;
      #1;
      tag = int'(m_rid[15]);
      chk("rnd_arvalid", m_arvalid, pend >= 0);
      chk("rnd_arready", s_arready, (pend >= 0 && m_arready) ? (1 << pend) : 0);
      if (pend >= 0) begin
        exp_id = 16'(pend << 15) | (16'(s_arid >> (16 * pend)) & 16'h7fff);
        chk("rnd_arid", m_arid, exp_id);
        chk("rnd_araddr", m_araddr, 64'(s_araddr >> (64 * pend)));
        chk("rnd_arlen", m_arlen, 8'(s_arlen >> (8 * pend)));
        chk("rnd_arsize", m_arsize, 3'(s_arsize >> (3 * pend)));
      end
      chk("rnd_srvalid", s_rvalid, m_rvalid ? (1 << tag) : 0);
      chk("rnd_mrready", m_rready, s_rready[tag]);
      chk("rnd_srid", s_rid, m_rid & 16'h7fff);
      chk("rnd_rpass", {s_rdata, s_rresp, s_rlast, s_ruser}, {rd, m_rresp, m_rlast, m_ruser});
      // Model update for the coming clock edge.
      delta = (m_rvalid && s_rready[tag] && m_rlast) ? -1 : 0;
      if (pend < 0) begin
        e0 = s_arvalid[0] && cnt[0] < 2;
        e1 = s_arvalid[1] && cnt[1] < 2;
        if (e0 && e1) pend = (last == 0) ? 1 : 0;
        else if (e0) pend = 0;
        else if (e1) pend = 1;
        if (delta < 0 && cnt[tag] > 0) cnt[tag]--;
      end else if (m_arready) begin
        if (pend == tag) delta++;
        else cnt[pend]++;
        if (delta > 0) cnt[tag]++;
        else if (delta < 0 && cnt[tag] > 0) cnt[tag]--;
        last = pend;
        pend = -1;
      end else begin
        if (delta < 0 && cnt[tag] > 0) cnt[tag]--;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
